// File: rtl/dm_rx_packet_writer.sv
// Receive-side packet writer: decodes [base][length][payload...] words from the
// photonic receiver and streams the payload into data_memory at consecutive addresses.
module dm_rx_packet_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_ready,
    input  logic                  core_hold,
    output logic                  memory_write_enable,
    output logic [ADDR_WIDTH-1:0] address_rw,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  pkt_wrapped,
    output logic [7:0]            pkt_count
);

    typedef enum logic [1:0] {
        S_ADDR,
        S_LEN,
        S_DATA
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0]   remaining_q, remaining_d;
    logic                    wrap_q, wrap_d;
    logic                    done_d, wrapped_d;
    logic                    accept;

    assign rx_ready   = !core_hold;
    assign accept     = rx_valid && rx_ready;
    assign address_rw = wr_ptr_q;
    assign data_in    = rx_data;
    assign busy       = (state_q != S_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        wr_ptr_d            = wr_ptr_q;
        remaining_d         = remaining_q;
        wrap_d              = wrap_q;
        done_d              = 1'b0;
        wrapped_d           = 1'b0;
        memory_write_enable = 1'b0;
        case (state_q)
            S_ADDR: begin
                if (accept) begin
                    wr_ptr_d = rx_data[ADDR_WIDTH-1:0];
                    wrap_d   = 1'b0;
                    state_d  = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (rx_data == '0) begin
                        state_d   = S_ADDR;
                        done_d    = 1'b1;
                        wrapped_d = wrap_q;
                    end else begin
                        remaining_d = rx_data;
                        state_d     = S_DATA;
                    end
                end
            end
            S_DATA: begin
                memory_write_enable = accept;
                if (accept) begin
                    wr_ptr_d    = wr_ptr_q + ADDR_ONE;
                    remaining_d = remaining_q - DATA_ONE;
                    if (wr_ptr_q == '1) begin
                        wrap_d = 1'b1;
                    end
                    // A wrap caused by the final word must still be reported with this packet.
                    if (remaining_q == DATA_ONE) begin
                        state_d   = S_ADDR;
                        done_d    = 1'b1;
                        wrapped_d = wrap_d;
                    end
                end
            end
            default: begin
                state_d = S_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_wrapped <= 1'b0;
            pkt_count   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
            pkt_done    <= done_d;
            pkt_wrapped <= wrapped_d;
            if (done_d) begin
                pkt_count <= pkt_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dm_rx_packet_writer.sv
// Self-checking bench for dm_rx_packet_writer: packet-level reference model checked
// every cycle, plus literal expectations on memory contents and counters.
module tb_dm_rx_packet_writer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       core_hold;
    logic       memory_write_enable;
    logic [7:0] address_rw;
    logic [7:0] data_in;
    logic       busy;
    logic       pkt_done;
    logic       pkt_wrapped;
    logic [7:0] pkt_count;

    int n_checks = 0;
    int n_fail   = 0;

    dm_rx_packet_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .rx_valid            (rx_valid),
        .rx_data             (rx_data),
        .rx_ready            (rx_ready),
        .core_hold           (core_hold),
        .memory_write_enable (memory_write_enable),
        .address_rw          (address_rw),
        .data_in             (data_in),
        .busy                (busy),
        .pkt_done            (pkt_done),
        .pkt_wrapped         (pkt_wrapped),
        .pkt_count           (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: position within the packet, base and length.
    int         m_idx;
    int         m_base;
    int         m_len;
    logic       m_done;
    logic       m_wrapped;
    logic [7:0] m_count;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_idx = 0; m_base = 0; m_len = 0;
            m_done = 1'b0; m_wrapped = 1'b0; m_count = 8'd0;
        end else begin
            m_done = 1'b0;
            m_wrapped = 1'b0;
            if (rx_valid && !core_hold) begin
                if (m_idx == 0) begin
                    m_base = int'(rx_data);
                    m_idx = 1;
                end else if (m_idx == 1) begin
                    if (rx_data == 8'd0) begin
                        m_idx = 0;
                        m_done = 1'b1;
                        m_count = m_count + 8'd1;
                    end else begin
                        m_len = int'(rx_data);
                        m_idx = 2;
                    end
                end else if (m_idx - 2 == m_len - 1) begin
                    m_idx = 0;
                    m_done = 1'b1;
                    m_wrapped = (m_base + m_len > 256);
                    m_count = m_count + 8'd1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    logic [7:0] tb_mem [256];
    logic       tb_written [256];
    int         n_writes = 0;

    // Per-cycle comparison and capture of memory writes (committed at the next rising edge).
    always @(negedge clk) begin
        logic exp_we;
        exp_we = reset_n && (m_idx >= 2) && rx_valid && !core_hold;
        chk("rx_ready", 32'(rx_ready), 32'(!core_hold));
        chk("write_enable", 32'(memory_write_enable), 32'(exp_we));
        chk("busy", 32'(busy), 32'(reset_n && m_idx != 0));
        chk("pkt_done", 32'(pkt_done), 32'(m_done));
        chk("pkt_wrapped", 32'(pkt_wrapped), 32'(m_wrapped));
        chk("pkt_count", 32'(pkt_count), 32'(m_count));
        if (exp_we) begin
            chk("address_rw", 32'(address_rw), 32'((m_base + m_idx - 2) % 256));
            chk("data_in", 32'(data_in), 32'(rx_data));
        end
        if (memory_write_enable) begin
            tb_mem[address_rw] = data_in;
            tb_written[address_rw] = 1'b1;
            n_writes++;
        end
    end

    task automatic send(input logic [7:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'h5A;
            @(posedge clk); #2;
        end
    endtask

    task automatic peek();
        @(negedge clk); #1;
    endtask

    int w0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'h00;
            tb_written[i] = 1'b0;
        end
        reset_n = 1'b0; rx_valid = 1'b1; rx_data = 8'h33; core_hold = 1'b0;

        // 1: reset with rx_valid high
        repeat (3) @(posedge clk);
        #2;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_done", 32'(pkt_done), 32'd0);
        chk("t1_count", 32'(pkt_count), 32'd0);
        chk("t1_we", 32'(memory_write_enable), 32'd0);
        rx_valid = 1'b0;
        reset_n = 1'b1;
        idle(1);

        // 2: simple packet
        send(8'h10); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
        rx_valid = 1'b0;
        peek();
        chk("t2_done", 32'(pkt_done), 32'd1);
        chk("t2_wrapped", 32'(pkt_wrapped), 32'd0);
        chk("t2_count", 32'(pkt_count), 32'd1);
        chk("t2_m10", 32'(tb_mem[8'h10]), 32'hAA);
        chk("t2_m11", 32'(tb_mem[8'h11]), 32'hBB);
        chk("t2_m12", 32'(tb_mem[8'h12]), 32'hCC);
        idle(1);

        // 3: wrapping packet, then 4 back-to-back: zero-length packet
        send(8'hFE); send(8'h04); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("t3_done", 32'(pkt_done), 32'd1);
        chk("t3_wrapped", 32'(pkt_wrapped), 32'd1);
        w0 = n_writes;
        send(8'h20);
        chk("t4_busy", 32'(busy), 32'd1);
        send(8'h00);
        rx_valid = 1'b0;
        peek();
        chk("t4_done", 32'(pkt_done), 32'd1);
        chk("t4_wrapped", 32'(pkt_wrapped), 32'd0);
        chk("t4_count", 32'(pkt_count), 32'd3);
        chk("t4_nowrite", 32'(n_writes - w0), 32'd0);
        chk("t3_mFE", 32'(tb_mem[8'hFE]), 32'h01);
        chk("t3_mFF", 32'(tb_mem[8'hFF]), 32'h02);
        chk("t3_m00", 32'(tb_mem[8'h00]), 32'h03);
        chk("t3_m01", 32'(tb_mem[8'h01]), 32'h04);
        idle(1);

        // 5: core_hold for 3 cycles mid-payload
        send(8'h80); send(8'h05); send(8'hA1); send(8'hA2);
        w0 = n_writes;
        core_hold = 1'b1;
        send(8'hEE); send(8'hEE); send(8'hEE);
        chk("t5_ready", 32'(rx_ready), 32'd0);
        chk("t5_hold_addr", 32'(address_rw), 32'h82);
        chk("t5_nowrite", 32'(n_writes - w0), 32'd0);
        core_hold = 1'b0;
        send(8'hA3); send(8'hA4); send(8'hA5);
        rx_valid = 1'b0;
        peek();
        chk("t5_count", 32'(pkt_count), 32'd4);
        chk("t5_m82", 32'(tb_mem[8'h82]), 32'hA3);
        chk("t5_m84", 32'(tb_mem[8'h84]), 32'hA5);
        chk("t5_m85", 32'(tb_written[8'h85]), 32'd0);
        idle(1);

        // 6: reset after 2 of 4 payload words
        send(8'h60); send(8'h04); send(8'h11); send(8'h22);
        rx_valid = 1'b1; rx_data = 8'h33;
        reset_n = 1'b0;
        @(posedge clk); #2;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_count", 32'(pkt_count), 32'd0);
        reset_n = 1'b1;
        send(8'h40); send(8'h01); send(8'h55);
        rx_valid = 1'b0;
        peek();
        chk("t6_done", 32'(pkt_done), 32'd1);
        chk("t6_count", 32'(pkt_count), 32'd1);
        chk("t6_m60", 32'(tb_mem[8'h60]), 32'h11);
        chk("t6_m61", 32'(tb_mem[8'h61]), 32'h22);
        chk("t6_m62", 32'(tb_written[8'h62]), 32'd0);
        chk("t6_m40", 32'(tb_mem[8'h40]), 32'h55);
        chk("t6_m20", 32'(tb_written[8'h20]), 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
